// File: rtl/multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared types and encodings for the multi-cycle RISC-V sequencer.
//   state_e     - FSM states
//   OP_* / F3_* - opcode and funct3 fields of the supported instructions
//   ALU_*, IMM_*, TC_* - ALUctrl, Immsrc and trap_cause encodings
//   ctl_t       - Moore control bundle, decoded per state by state_ctl()
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        BRANCH,
        TRAP
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_B = 2'b01;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    // Controls that depend on state alone; PCsrc and IRWrite also look at
    // inputs and are built in the top.
    typedef struct packed {
        logic       imem_req;
        logic       reg_write;
        logic       pc_write;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [1:0] imm_src;
        logic       retire;
        logic       trap;
    } ctl_t;

    function automatic ctl_t state_ctl(input state_e s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: c.imem_req = 1'b1;
            EXECUTE: begin
                c.alu_ctrl = ALU_ADD;
                c.alu_src  = 1'b1;
                c.imm_src  = IMM_I;
            end
            WRITEBACK: begin
                c.alu_ctrl  = ALU_ADD;
                c.alu_src   = 1'b1;
                c.imm_src   = IMM_I;
                c.reg_write = 1'b1;
                c.pc_write  = 1'b1;
                c.retire    = 1'b1;
            end
            BRANCH: begin
                c.alu_ctrl = ALU_SUB;
                c.alu_src  = 1'b0;
                c.imm_src  = IMM_B;
                c.pc_write = 1'b1;
                c.retire   = 1'b1;
            end
            TRAP:    c.trap = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction-memory handshake, instruction/flag inputs
// and datapath controls of the multi-cycle sequencer.
//   master - the sequencer (drives imem_req and all datapath controls)
//   slave  - memory/datapath side (drives instr, EQ, imem_valid)
interface multicycle_ctrl_if #(
    parameter int INSTR_LEN = 32
);
    logic [INSTR_LEN-1:0] instr;
    logic                 EQ;
    logic                 imem_valid;
    logic                 imem_req;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic [2:0]           ALUctrl;
    logic                 ALUsrc;
    logic [1:0]           Immsrc;
    logic                 PCsrc;
    logic                 retire;
    logic                 trap;
    logic [1:0]           trap_cause;

    modport master (
        input  instr, EQ, imem_valid,
        output imem_req, IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc,
               Immsrc, PCsrc, retire, trap, trap_cause
    );

    modport slave (
        output instr, EQ, imem_valid,
        input  imem_req, IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc,
               Immsrc, PCsrc, retire, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_ctrl_fetch_timer.sv
// fetch_timer: saturating count of consecutive FETCH cycles without a memory
// response.
//   clk, rst  - clock, synchronous active-high reset
//   clr_i     - hold the count at zero
//   en_i      - count this cycle (in FETCH, no imem_valid)
//   expired_o - this counted cycle reaches FETCH_TIMEOUT (never when 0)
module fetch_timer
    import rv_ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15,
    parameter int TMO_W         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    // cnt_q holds the misses already seen, so the current miss is the
    // (cnt_q+1)-th; it expires when that equals FETCH_TIMEOUT.
    localparam logic [TMO_W-1:0] LIMIT =
        (FETCH_TIMEOUT == 0) ? '0 : TMO_W'(FETCH_TIMEOUT - 1);
    localparam bit ENABLED = (FETCH_TIMEOUT != 0);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = ENABLED && en_i && (cnt_q >= LIMIT);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for addi/beq/bne.
//   clk, rst - clock, synchronous active-high reset (forces all outputs 0)
//   bus      - multicycle_ctrl_if.master: imem req/valid handshake, instr,
//              EQ, and datapath controls, retire, trap, trap_cause
// FETCH -> DECODE -> EXECUTE -> WRITEBACK (addi) or DECODE -> BRANCH;
// illegal opcodes and fetch timeouts park in TRAP until reset.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int INSTR_LEN     = 32,
    parameter int FETCH_TIMEOUT = 15,
    parameter int TMO_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus
);
    // Decode reads opcode and funct3 directly, so the word must cover them.
    if (INSTR_LEN < 15) begin : g_len_chk
        $error("multicycle_ctrl: INSTR_LEN too small for funct3 field");
    end

    state_e     state_q;
    ctl_t       ctl_q;
    logic [1:0] cause_q;
    logic       tmr_expired;

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];

    // Held at zero outside FETCH, so every entry to FETCH starts fresh.
    fetch_timer #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .TMO_W         (TMO_W)
    ) u_fetch_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != FETCH),
        .en_i      ((state_q == FETCH) && !bus.imem_valid),
        .expired_o (tmr_expired)
    );

    // ctl_q is loaded with the decode of the state being entered, so it is
    // always the Moore decode of state_q, one register stage earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ctl_q   <= state_ctl(FETCH);
            cause_q <= TC_NONE;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.imem_valid) begin
                        state_q <= DECODE;
                        ctl_q   <= state_ctl(DECODE);
                    end else if (tmr_expired) begin
                        state_q <= TRAP;
                        ctl_q   <= state_ctl(TRAP);
                        cause_q <= TC_TIMEOUT;
                    end
                end
                DECODE: begin
                    if (opcode == OP_IMM && funct3 == F3_ADDI) begin
                        state_q <= EXECUTE;
                        ctl_q   <= state_ctl(EXECUTE);
                    end else if (opcode == OP_BRANCH &&
                                 (funct3 == F3_BEQ || funct3 == F3_BNE)) begin
                        state_q <= BRANCH;
                        ctl_q   <= state_ctl(BRANCH);
                    end else begin
                        state_q <= TRAP;
                        ctl_q   <= state_ctl(TRAP);
                        cause_q <= TC_ILLEGAL;
                    end
                end
                EXECUTE: begin
                    state_q <= WRITEBACK;
                    ctl_q   <= state_ctl(WRITEBACK);
                end
                WRITEBACK, BRANCH: begin
                    state_q <= FETCH;
                    ctl_q   <= state_ctl(FETCH);
                end
                TRAP: ;
                default: begin
                    state_q <= FETCH;
                    ctl_q   <= state_ctl(FETCH);
                end
            endcase
        end
    end

    logic on;
    assign on = !rst;

    assign bus.imem_req   = on && ctl_q.imem_req;
    assign bus.RegWrite   = on && ctl_q.reg_write;
    assign bus.PCWrite    = on && ctl_q.pc_write;
    assign bus.ALUctrl    = on ? ctl_q.alu_ctrl : 3'b000;
    assign bus.ALUsrc     = on && ctl_q.alu_src;
    assign bus.Immsrc     = on ? ctl_q.imm_src : 2'b00;
    assign bus.retire     = on && ctl_q.retire;
    assign bus.trap       = on && ctl_q.trap;
    assign bus.trap_cause = on ? cause_q : TC_NONE;

    assign bus.IRWrite = on && (state_q == FETCH) && bus.imem_valid;
    // bne takes the branch on inequality, beq on equality.
    assign bus.PCsrc   = on && (state_q == BRANCH) &&
                         ((funct3 == F3_BNE) ? !bus.EQ : bus.EQ);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: addi, beq/bne both ways, illegal trap,
// fetch timeout and its boundary, and reset mid-instruction.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTR_LEN(32)) bus ();

    multicycle_ctrl #(
        .INSTR_LEN     (32),
        .FETCH_TIMEOUT (15),
        .TMO_W         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {req, irw, pcw, rw, alu[3], asrc, imm[2], pcsrc, retire, trap, cause[2]}
    function automatic logic [14:0] outv();
        return {bus.imem_req, bus.IRWrite, bus.PCWrite, bus.RegWrite,
                bus.ALUctrl, bus.ALUsrc, bus.Immsrc, bus.PCsrc,
                bus.retire, bus.trap, bus.trap_cause};
    endfunction

    function automatic logic [14:0] ev(input logic req, irw, pcw, rw,
                                       input logic [2:0] alu, input logic asrc,
                                       input logic [1:0] imm, input logic pcs,
                                       ret, trp, input logic [1:0] tc);
        return {req, irw, pcw, rw, alu, asrc, imm, pcs, ret, trp, tc};
    endfunction

    logic [14:0] V_ZERO, V_FETCH, V_FETCH_IR, V_EXEC, V_WB;

    task automatic check(input string tag, input logic [31:0] got, exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present a word in the current FETCH cycle and move into DECODE.
    task automatic fetch_hit(input logic [31:0] iw, input string tag);
        bus.instr      = iw;
        bus.imem_valid = 1'b1;
        #1 check({tag, "_fetch"}, 32'(outv()), 32'(V_FETCH_IR));
        cyc();
        bus.imem_valid = 1'b0;
        #1 check({tag, "_decode"}, 32'(outv()), 32'(V_ZERO));
    endtask

    task automatic do_branch(input logic [31:0] iw, input logic eq,
                             input logic pcs, input string tag);
        bus.EQ = eq;
        fetch_hit(iw, tag);
        cyc();
        #1 check({tag, "_branch"}, 32'(outv()),
                 32'(ev(0, 0, 1, 0, 3'b001, 0, 2'b01, pcs, 1, 0, 2'b00)));
        cyc();
        #1 check({tag, "_refetch"}, 32'(outv()), 32'(V_FETCH));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        V_ZERO     = '0;
        V_FETCH    = ev(1, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00);
        V_FETCH_IR = ev(1, 1, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00);
        V_EXEC     = ev(0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 2'b00);
        V_WB       = ev(0, 0, 1, 1, 3'b000, 1, 2'b00, 0, 1, 0, 2'b00);

        rst = 1'b1; bus.instr = '0; bus.EQ = 1'b0; bus.imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        #1 check("reset_outs", 32'(outv()), 32'(V_ZERO));
        rst = 1'b0;
        #1 check("reset_fetch", 32'(outv()), 32'(V_FETCH));

        // addi x1,x0,5: FETCH(1) DECODE(2) EXECUTE(3) WRITEBACK(4) FETCH(5)
        fetch_hit(32'h00500093, "addi");
        cyc(); #1 check("addi_exec", 32'(outv()), 32'(V_EXEC));
        cyc(); #1 check("addi_wb", 32'(outv()), 32'(V_WB));
        cyc(); #1 check("addi_cycle5", 32'(outv()), 32'(V_FETCH));

        do_branch(32'h00000463, 1'b1, 1'b1, "beq_eq1");
        do_branch(32'h00000463, 1'b0, 1'b0, "beq_eq0");
        do_branch(32'hFE009EE3, 1'b0, 1'b1, "bne_eq0");
        do_branch(32'hFE009EE3, 1'b1, 1'b0, "bne_eq1");
        bus.EQ = 1'b0;

        // R-type add: illegal, trap persists and ignores imem_valid.
        fetch_hit(32'h00000033, "illegal");
        cyc(); #1 check("illegal_trap", 32'(outv()),
                        32'(ev(0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 1, 2'b01)));
        bus.imem_valid = 1'b1;
        cyc(); #1 check("illegal_hold", 32'(outv()),
                        32'(ev(0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 1, 2'b01)));
        bus.imem_valid = 1'b0;
        rst = 1'b1;
        #1 check("trap_rst_outs", 32'(outv()), 32'(V_ZERO));
        cyc();
        rst = 1'b0;
        #1 check("trap_rst_fetch", 32'(outv()), 32'(V_FETCH));

        // Timeout: 15 missed FETCH cycles, trap on the edge after the 15th.
        for (int i = 1; i <= 15; i++) begin
            #1 check($sformatf("tmo_fetch%0d", i), 32'(outv()), 32'(V_FETCH));
            cyc();
        end
        #1 check("tmo_trap", 32'(outv()),
                 32'(ev(0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 1, 2'b10)));
        do_reset();

        // Valid arriving on the 15th cycle wins over the timeout.
        repeat (14) cyc();
        #1 check("tmo_edge_wait", 32'(outv()), 32'(V_FETCH));
        fetch_hit(32'h00500093, "tmo_edge");
        cyc(); #1 check("tmo_edge_exec", 32'(outv()), 32'(V_EXEC));
        cyc(); #1 check("tmo_edge_wb", 32'(outv()), 32'(V_WB));
        cyc();
        // Count must restart on re-entry: 14 more misses are still legal.
        repeat (14) cyc();
        #1 check("tmo_clear_wait", 32'(outv()), 32'(V_FETCH));
        fetch_hit(32'h00000463, "tmo_clear");
        do_reset();

        // Reset during WRITEBACK.
        fetch_hit(32'h00500093, "rst_wb");
        cyc(); cyc();
        #1 check("rst_wb_pre", 32'(outv()), 32'(V_WB));
        rst = 1'b1;
        #1 check("rst_wb_outs", 32'(outv()), 32'(V_ZERO));
        cyc();
        rst = 1'b0;
        #1 check("rst_wb_fetch", 32'(outv()), 32'(V_FETCH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
